// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and the uart_tx start/busy handshake, bundled for the arbiter.
// The arbiter takes the slave view; the client side and uart_tx take the master view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one uart_tx from N_REQ byte-stream requesters.
// Each granted byte is latched into tx_data and sequenced through tx_start/tx_busy.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int GAP_TIMEOUT  = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_arbiter_if.slave         bus,
  output logic                     grant_active,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_busy_to,
  output logic                     err_gap_to
);
  localparam int IDW = $clog2(N_REQ);
  localparam int BCW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GCW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [BCW-1:0] BUSY_LIMIT = BCW'(BUSY_TIMEOUT - 1);
  localparam logic [BCW-1:0] BUSY_ONE   = BCW'(1);
  localparam logic [GCW-1:0] GAP_LIMIT  = GCW'(GAP_TIMEOUT - 1);
  localparam logic [GCW-1:0] GAP_ONE    = GCW'(1);
  localparam logic [IDW:0]   N_WIDE     = (IDW + 1)'(N_REQ);
  localparam logic [IDW-1:0] ID_ONE     = IDW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEL       = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               grant_active_q, grant_active_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic               started_q, started_d;
  logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [BCW-1:0]     busy_cnt_q, busy_cnt_d;
  logic               err_busy_q, err_busy_d;
  logic               err_gap_q, err_gap_d;
  logic [IDW-1:0]     pick_id;
  logic               pick_found;
  logic               xfer;
  logic [IDW-1:0]     next_id;

  // (base + step) mod N_REQ, with both operands already below N_REQ.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input logic [IDW-1:0] step);
    logic [IDW:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= N_WIDE) begin
      sum = sum - N_WIDE;
    end else begin
      sum = sum;
    end
    return sum[IDW-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
    return {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  assign pick_found = |bus.req_valid;
  assign xfer       = bus.req_valid[grant_id_q] & req_ready_q[grant_id_q];
  assign next_id    = wrap_inc(grant_id_q, ID_ONE);

  // Round-robin scan: walking from the far end back to the pointer leaves the nearest requester.
  always_comb begin
    pick_id = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pick_id = bus.req_valid[wrap_inc(ptr_q, IDW'(i))] ? wrap_inc(ptr_q, IDW'(i)) : pick_id;
    end
  end

  // Next-state and next-output computation for the grant/transmit sequencer.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_active_d = grant_active_q;
    grant_id_d     = grant_id_q;
    req_ready_d    = '0;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    started_d      = started_q;
    gap_cnt_d      = gap_cnt_q;
    busy_cnt_d     = busy_cnt_q;
    err_busy_d     = err_busy_q;
    err_gap_d      = err_gap_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d        = S_SEL;
          grant_active_d = 1'b1;
          grant_id_d     = pick_id;
          req_ready_d    = onehot(pick_id);
          started_d      = 1'b0;
          gap_cnt_d      = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEL: begin
        if (xfer) begin
          tx_data_d  = bus.req_data[{grant_id_q, 3'b000} +: 8];
          last_d     = bus.req_last[grant_id_q];
          started_d  = 1'b1;
          tx_start_d = 1'b1;
          state_d    = S_START;
        end else if (started_q && (gap_cnt_q == GAP_LIMIT)) begin
          err_gap_d      = 1'b1;
          grant_active_d = 1'b0;
          ptr_d          = next_id;
          state_d        = S_IDLE;
        end else begin
          // A fresh grant (no byte sent yet) is never timed out.
          req_ready_d = onehot(grant_id_q);
          gap_cnt_d   = started_q ? (gap_cnt_q + GAP_ONE) : gap_cnt_q;
        end
      end
      S_START: begin
        // Counter holds cycles elapsed since the tx_start pulse.
        busy_cnt_d = BUSY_ONE;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (busy_cnt_q >= BUSY_LIMIT) begin
          err_busy_d = 1'b1;
          state_d    = S_WAIT_DONE;
        end else begin
          busy_cnt_d = busy_cnt_q + BUSY_ONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (last_q) begin
          grant_active_d = 1'b0;
          ptr_d          = next_id;
          state_d        = S_IDLE;
        end else begin
          req_ready_d = onehot(grant_id_q);
          gap_cnt_d   = '0;
          state_d     = S_SEL;
        end
      end
      default: begin
        grant_active_d = 1'b0;
        state_d        = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      grant_active_q <= 1'b0;
      grant_id_q     <= '0;
      req_ready_q    <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      last_q         <= 1'b0;
      started_q      <= 1'b0;
      gap_cnt_q      <= '0;
      busy_cnt_q     <= '0;
      err_busy_q     <= 1'b0;
      err_gap_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_active_q <= grant_active_d;
      grant_id_q     <= grant_id_d;
      req_ready_q    <= req_ready_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
      started_q      <= started_d;
      gap_cnt_q      <= gap_cnt_d;
      busy_cnt_q     <= busy_cnt_d;
      err_busy_q     <= err_busy_d;
      err_gap_q      <= err_gap_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign grant_active  = grant_active_q;
  assign grant_id      = grant_id_q;
  assign err_busy_to   = err_busy_q;
  assign err_gap_to    = err_gap_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requester sources, a simple uart_tx responder,
// and one task per scenario with hand-derived cycle-exact expectations.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       grant_active;
  logic [1:0] grant_id;
  logic       err_busy_to;
  logic       err_gap_to;
  logic       busy_en = 1'b1;
  logic [8:0] rq [4][$];
  logic [7:0] sent [$];
  int         n_start = 0;
  int         n_overlap = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(8), .GAP_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .err_busy_to  (err_busy_to),
    .err_gap_to   (err_gap_to)
  );

  always #5 clk = ~clk;

  // Requester sources: each queue entry is {last, data}; pop on a completed handshake.
  initial begin
    logic [3:0] fire;
    bus.req_valid = 4'b0000;
    bus.req_data  = 32'h0;
    bus.req_last  = 4'b0000;
    forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_data[8*i +: 8]  = rq[i][0][7:0];
          bus.req_last[i]         = rq[i][0][8];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // uart_tx stand-in: busy rises 2 cycles after tx_start and lasts 6 cycles.
  initial begin
    int dly;
    int left;
    dly = 0;
    left = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        sent.push_back(bus.tx_data);
        n_start++;
        if (bus.tx_busy === 1'b1) n_overlap++;
        if (busy_en) dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          bus.tx_busy = 1'b1;
          left = 6;
        end
      end else if (left > 0) begin
        left--;
        if (left == 0) bus.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (grant_active !== 1'b0) begin n_fail++; $display("FAIL rst_grant_active: got %0h expected 0", grant_active); end
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0h expected 0", grant_id); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %0h expected 0", bus.tx_start); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %0h expected 00", bus.tx_data); end
    n_cmp++; if ({err_busy_to, err_gap_to} !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b expected 00", {err_busy_to, err_gap_to}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_byte;
    int base;
    int k;
    base = sent.size();
    @(negedge clk);
    rq[2].push_back({1'b1, 8'h41});
    tick();
    n_cmp++; if (grant_active !== 1'b0) begin n_fail++; $display("FAIL sb_not_yet: got %0h expected 0", grant_active); end
    tick();
    n_cmp++; if ({grant_active, grant_id} !== 3'b110) begin n_fail++; $display("FAIL sb_grant: got %b expected 110", {grant_active, grant_id}); end
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL sb_ready: got %b expected 0100", bus.req_ready); end
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_fail++; $display("FAIL sb_start_early: got %0h expected 0", bus.tx_start); end
    tick();
    n_cmp++; if (bus.tx_start !== 1'b1) begin n_fail++; $display("FAIL sb_start: got %0h expected 1", bus.tx_start); end
    n_cmp++; if (bus.tx_data !== 8'h41) begin n_fail++; $display("FAIL sb_data: got %0h expected 41", bus.tx_data); end
    for (k = 0; k < 60 && grant_active !== 1'b0; k++) tick();
    n_cmp++; if (k >= 60) begin n_fail++; $display("FAIL sb_release: got timeout expected grant drop"); end
    n_cmp++; if (err_busy_to !== 1'b0) begin n_fail++; $display("FAIL sb_err_busy: got %0h expected 0", err_busy_to); end
    // Pointer now 3: with req0 and req3 pending, req3 must win.
    @(negedge clk);
    rq[0].push_back({1'b1, 8'h30});
    rq[3].push_back({1'b1, 8'h33});
    tick();
    tick();
    n_cmp++; if ({grant_active, grant_id} !== 3'b111) begin n_fail++; $display("FAIL sb_ptr3: got %b expected 111", {grant_active, grant_id}); end
    for (k = 0; k < 200 && !(sent.size() == base + 3 && grant_active === 1'b0); k++) tick();
    n_cmp++; if (k >= 200) begin n_fail++; $display("FAIL sb_drain: got timeout expected 3 bytes"); end
    n_cmp++; if (sent[base+1] !== 8'h33) begin n_fail++; $display("FAIL sb_order0: got %0h expected 33", sent[base+1]); end
    n_cmp++; if (sent[base+2] !== 8'h30) begin n_fail++; $display("FAIL sb_order1: got %0h expected 30", sent[base+2]); end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_rr [5];
    int base;
    int s0;
    int o0;
    int k;
    exp_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    base = sent.size();
    s0 = n_start;
    o0 = n_overlap;
    @(negedge clk);
    rq[0].push_back({1'b1, 8'h10});
    rq[0].push_back({1'b1, 8'h10});
    rq[1].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h12});
    rq[3].push_back({1'b1, 8'h13});
    for (k = 0; k < 400 && !(sent.size() == base + 5 && grant_active === 1'b0); k++) tick();
    n_cmp++; if (k >= 400) begin n_fail++; $display("FAIL rr_drain: got timeout expected 5 bytes"); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (sent[base+i] !== exp_rr[i]) begin n_fail++; $display("FAIL rr_byte%0d: got %0h expected %0h", i, sent[base+i], exp_rr[i]); end
    end
    n_cmp++; if (n_start - s0 != 5) begin n_fail++; $display("FAIL rr_starts: got %0d expected 5", n_start - s0); end
    n_cmp++; if (n_overlap != o0) begin n_fail++; $display("FAIL rr_overlap: got %0d expected %0d", n_overlap, o0); end
  endtask

  task automatic test_packet_lock;
    logic [7:0] exp_pl [4];
    int base;
    int k;
    int viol;
    exp_pl = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
    do_reset();
    base = sent.size();
    viol = 0;
    @(negedge clk);
    rq[0].push_back({1'b0, 8'hA0});
    rq[0].push_back({1'b0, 8'hA1});
    rq[0].push_back({1'b1, 8'hA2});
    rq[1].push_back({1'b1, 8'hB0});
    for (k = 0; k < 400 && !(sent.size() == base + 4 && grant_active === 1'b0); k++) begin
      tick();
      if (bus.req_ready[1] === 1'b1 && (sent.size() < base + 3 || grant_id !== 2'd1)) viol++;
    end
    n_cmp++; if (k >= 400) begin n_fail++; $display("FAIL pl_drain: got timeout expected 4 bytes"); end
    n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL pl_lock: got %0d early ready1 cycles expected 0", viol); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sent[base+i] !== exp_pl[i]) begin n_fail++; $display("FAIL pl_byte%0d: got %0h expected %0h", i, sent[base+i], exp_pl[i]); end
    end
    n_cmp++; if (err_gap_to !== 1'b0) begin n_fail++; $display("FAIL pl_err_gap: got %0h expected 0", err_gap_to); end
  endtask

  task automatic test_busy_timeout;
    int k;
    do_reset();
    busy_en = 1'b0;
    @(negedge clk);
    rq[0].push_back({1'b1, 8'h5A});
    for (k = 0; k < 20 && bus.tx_start !== 1'b1; k++) tick();
    n_cmp++; if (k >= 20) begin n_fail++; $display("FAIL bt_start: got timeout expected tx_start"); end
    repeat (7) tick();
    n_cmp++; if (err_busy_to !== 1'b0) begin n_fail++; $display("FAIL bt_early: got %0h expected 0 at start+7", err_busy_to); end
    tick();
    n_cmp++; if (err_busy_to !== 1'b1) begin n_fail++; $display("FAIL bt_flag: got %0h expected 1 at start+8", err_busy_to); end
    n_cmp++; if (grant_active !== 1'b1) begin n_fail++; $display("FAIL bt_still_granted: got %0h expected 1", grant_active); end
    tick();
    n_cmp++; if (grant_active !== 1'b0) begin n_fail++; $display("FAIL bt_idle: got %0h expected 0", grant_active); end
    busy_en = 1'b1;
    tick();
  endtask

  task automatic test_gap_timeout;
    int base;
    int k;
    do_reset();
    base = sent.size();
    @(negedge clk);
    rq[1].push_back({1'b0, 8'h21});
    rq[2].push_back({1'b1, 8'h22});
    for (k = 0; k < 100 && !(sent.size() == base + 1 && bus.req_ready[1] === 1'b1); k++) tick();
    n_cmp++; if (k >= 100) begin n_fail++; $display("FAIL gt_resel: got timeout expected return to SEL"); end
    repeat (15) tick();
    n_cmp++; if ({err_gap_to, grant_active} !== 2'b01) begin n_fail++; $display("FAIL gt_early: got %b expected 01", {err_gap_to, grant_active}); end
    tick();
    n_cmp++; if ({err_gap_to, grant_active} !== 2'b10) begin n_fail++; $display("FAIL gt_flag: got %b expected 10", {err_gap_to, grant_active}); end
    tick();
    n_cmp++; if ({grant_active, grant_id} !== 3'b110) begin n_fail++; $display("FAIL gt_regrant: got %b expected 110", {grant_active, grant_id}); end
    for (k = 0; k < 100 && !(sent.size() == base + 2 && grant_active === 1'b0); k++) tick();
    n_cmp++; if (sent[base+1] !== 8'h22) begin n_fail++; $display("FAIL gt_req2: got %0h expected 22", sent[base+1]); end
  endtask

  task automatic test_reset_mid_frame;
    int s0;
    int k;
    // Pointer sits at 3 from the previous packet; a new req3 packet gets to WAIT_DONE.
    @(negedge clk);
    rq[3].push_back({1'b1, 8'h55});
    for (k = 0; k < 40 && bus.tx_busy !== 1'b1; k++) tick();
    n_cmp++; if (k >= 40) begin n_fail++; $display("FAIL rm_busy: got timeout expected tx_busy"); end
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({grant_active, grant_id} !== 3'b000) begin n_fail++; $display("FAIL rm_grant: got %b expected 000", {grant_active, grant_id}); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rm_tx_data: got %0h expected 00", bus.tx_data); end
    n_cmp++; if ({bus.req_ready, bus.tx_start} !== 5'b00000) begin n_fail++; $display("FAIL rm_ready_start: got %b expected 00000", {bus.req_ready, bus.tx_start}); end
    n_cmp++; if ({err_busy_to, err_gap_to} !== 2'b00) begin n_fail++; $display("FAIL rm_err: got %b expected 00", {err_busy_to, err_gap_to}); end
    rst_n = 1'b1;
    s0 = n_start;
    repeat (10) tick();
    n_cmp++; if (n_start != s0) begin n_fail++; $display("FAIL rm_no_start: got %0d starts expected 0", n_start - s0); end
    @(negedge clk);
    rq[0].push_back({1'b1, 8'h60});
    rq[3].push_back({1'b1, 8'h63});
    tick();
    tick();
    n_cmp++; if ({grant_active, grant_id} !== 3'b100) begin n_fail++; $display("FAIL rm_ptr0: got %b expected 100", {grant_active, grant_id}); end
    for (k = 0; k < 200 && !(rq[0].size() == 0 && rq[3].size() == 0 && grant_active === 1'b0); k++) tick();
    n_cmp++; if (k >= 200) begin n_fail++; $display("FAIL rm_drain: got timeout expected idle"); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_busy_timeout();
    test_gap_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
